kfx86_muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for unsigned MUL/DIV (byte and word) that drives the shared combinational ALU.

---
 rtl/kfx86_muldiv_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_kfx86_muldiv_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/kfx86_muldiv_sequencer.sv
// kfx86_muldiv_sequencer
//   Multi-cycle sequencer for unsigned MUL/DIV in byte (N=8) and word (N=16)
//   modes. It runs a shift-add multiply or a restoring divide, one pass through
//   the shared combinational ALU per clock. It drives the ALU ports only while
//   it is in LOOP.
//
// Ports
//   clock_i, reset_i         clock; synchronous active-high reset
//   start_i                  request, accepted only in IDLE
//   op_div_i                 0 = MUL, 1 = DIV (sampled with start)
//   select_word_i            0 = byte, 1 = word (sampled with start)
//   operand_hi_i             DIV dividend high half
//   operand_lo_i             MUL multiplicand / DIV dividend low half
//   operand_src_i            MUL multiplier / DIV divisor
//   busy_o, done_o           busy from the cycle after accept through DONE; done in DONE
//   divide_error_o           divide by zero or quotient overflow
//   result_hi_o/result_lo_o  MUL high/low product, DIV remainder/quotient
//   mul_overflow_o           MUL with a non-zero high half
//   alu_opcode_o, alu_source_1_o, alu_source_2_o, alu_select_word_o   to the ALU
//   alu_out_i, alu_carry_i   from the ALU; carry is the borrow for SUB

`ifndef ALU_OP_ADD
`define ALU_OP_ADD 5'h01
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 5'h05
`endif

module kfx86_muldiv_sequencer (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        op_div_i,
  input  logic        select_word_i,
  input  logic [15:0] operand_hi_i,
  input  logic [15:0] operand_lo_i,
  input  logic [15:0] operand_src_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        divide_error_o,
  output logic [15:0] result_hi_o,
  output logic [15:0] result_lo_o,
  output logic        mul_overflow_o,
  output logic [4:0]  alu_opcode_o,
  output logic [15:0] alu_source_1_o,
  output logic [15:0] alu_source_2_o,
  output logic        alu_select_word_o,
  input  logic [15:0] alu_out_i,
  input  logic        alu_carry_i
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOOP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        op_div_q, op_div_d;
  logic        word_q, word_d;
  // acc: MUL accumulator / DIV partial remainder
  // mq: MUL multiplier / DIV quotient
  // mcand: MUL multiplicand / DIV divisor
  logic [15:0] acc_q, acc_d;
  logic [15:0] mq_q, mq_d;
  logic [15:0] mcand_q, mcand_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] res_hi_q, res_hi_d;
  logic [15:0] res_lo_q, res_lo_d;
  logic        div_err_q, div_err_d;
  logic        mul_ovf_q, mul_ovf_d;

  logic [15:0] mask, mask_in, alu_res, t_low, acc_new;
  logic        t_msb, last_iter, c_bit, qbit;

  assign mask      = word_q ? 16'hFFFF : 16'h00FF;
  assign mask_in   = select_word_i ? 16'hFFFF : 16'h00FF;
  assign alu_res   = alu_out_i & mask;
  assign last_iter = (iter_q == (word_q ? 4'd15 : 4'd7));
  // Restoring-divide trial value t = {rem, q[N-1]}. t_msb is bit N, and the
  // low N bits go to the ALU.
  assign t_msb     = word_q ? acc_q[15] : acc_q[7];
  assign t_low     = word_q ? {acc_q[14:0], mq_q[15]} : {8'h00, acc_q[6:0], mq_q[7]};

  always_comb begin
    state_d           = state_q;
    op_div_d          = op_div_q;
    word_d            = word_q;
    acc_d             = acc_q;
    mq_d              = mq_q;
    mcand_d           = mcand_q;
    iter_d            = iter_q;
    res_hi_d          = res_hi_q;
    res_lo_d          = res_lo_q;
    div_err_d         = div_err_q;
    mul_ovf_d         = mul_ovf_q;
    alu_opcode_o      = 5'h00;
    alu_source_1_o    = 16'h0000;
    alu_source_2_o    = 16'h0000;
    alu_select_word_o = 1'b0;
    acc_new           = acc_q;
    c_bit             = 1'b0;
    qbit              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_div_d = op_div_i;
          word_d   = select_word_i;
          iter_d   = 4'd0;
          if (op_div_i) begin
            acc_d   = operand_hi_i & mask_in;
            mq_d    = operand_lo_i & mask_in;
            mcand_d = operand_src_i & mask_in;
            state_d = S_CHECK;
          end else begin
            acc_d   = 16'h0000;
            mq_d    = operand_src_i & mask_in;
            mcand_d = operand_lo_i & mask_in;
            state_d = S_LOOP;
          end
        end
      end

      S_CHECK: begin
        // If the high half already reaches the divisor, the quotient would not
        // fit in N bits.
        if (mcand_q == 16'h0000 || acc_q >= mcand_q) begin
          state_d   = S_DONE;
          res_hi_d  = 16'h0000;
          res_lo_d  = 16'h0000;
          div_err_d = 1'b1;
          mul_ovf_d = 1'b0;
        end else begin
          state_d = S_LOOP;
        end
      end

      S_LOOP: begin
        alu_select_word_o = word_q;
        alu_source_2_o    = mcand_q;
        iter_d            = iter_q + 4'd1;
        if (op_div_q) begin
          alu_opcode_o   = `ALU_OP_SUB;
          alu_source_1_o = t_low;
          // A set bit N means t already exceeds any N-bit divisor.
          if (t_msb | ~alu_carry_i) begin
            acc_d = alu_res;
            qbit  = 1'b1;
          end else begin
            acc_d = t_low;
          end
          mq_d = ((mq_q << 1) | {15'h0000, qbit}) & mask;
        end else begin
          alu_opcode_o   = `ALU_OP_ADD;
          alu_source_1_o = acc_q;
          if (mq_q[0]) begin
            c_bit   = alu_carry_i;
            acc_new = alu_res;
          end
          acc_d = word_q ? {c_bit, acc_new[15:1]} : {8'h00, c_bit, acc_new[7:1]};
          mq_d  = word_q ? {acc_new[0], mq_q[15:1]} : {8'h00, acc_new[0], mq_q[7:1]};
        end
        if (last_iter) begin
          state_d   = S_DONE;
          res_hi_d  = acc_d;
          res_lo_d  = mq_d;
          div_err_d = 1'b0;
          mul_ovf_d = ~op_div_q & (acc_d != 16'h0000);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_div_q  <= 1'b0;
      word_q    <= 1'b0;
      acc_q     <= 16'h0000;
      mq_q      <= 16'h0000;
      mcand_q   <= 16'h0000;
      iter_q    <= 4'd0;
      res_hi_q  <= 16'h0000;
      res_lo_q  <= 16'h0000;
      div_err_q <= 1'b0;
      mul_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_div_q  <= op_div_d;
      word_q    <= word_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      iter_q    <= iter_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      div_err_q <= div_err_d;
      mul_ovf_q <= mul_ovf_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign divide_error_o = div_err_q;
  assign mul_overflow_o = mul_ovf_q;
  assign result_hi_o    = res_hi_q;
  assign result_lo_o    = res_lo_q;

endmodule

// File: tb/tb_kfx86_muldiv_sequencer.sv
// Self-checking bench for kfx86_muldiv_sequencer. A behavioural ALU closes the
// loop. Stimulus pushes expected results into a scoreboard, and a negedge
// monitor pops and compares them on every done pulse.

`ifndef ALU_OP_ADD
`define ALU_OP_ADD 5'h01
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 5'h05
`endif

module tb_kfx86_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, op_div, select_word;
  logic [15:0] operand_hi, operand_lo, operand_src;
  logic        busy, done, divide_error, mul_overflow;
  logic [15:0] result_hi, result_lo;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_source_1, alu_source_2;
  logic        alu_select_word;
  logic [15:0] alu_out;
  logic        alu_carry;

  kfx86_muldiv_sequencer dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .op_div_i(op_div),
    .select_word_i(select_word), .operand_hi_i(operand_hi), .operand_lo_i(operand_lo),
    .operand_src_i(operand_src), .busy_o(busy), .done_o(done),
    .divide_error_o(divide_error), .result_hi_o(result_hi), .result_lo_o(result_lo),
    .mul_overflow_o(mul_overflow), .alu_opcode_o(alu_opcode),
    .alu_source_1_o(alu_source_1), .alu_source_2_o(alu_source_2),
    .alu_select_word_o(alu_select_word), .alu_out_i(alu_out), .alu_carry_i(alu_carry)
  );

  always #5 clock = ~clock;

  // Behavioural shared ALU. For SUB, carry is the borrow.
  always_comb begin
    logic [15:0] m, a, b;
    logic [16:0] s;
    m = alu_select_word ? 16'hFFFF : 16'h00FF;
    a = alu_source_1 & m;
    b = alu_source_2 & m;
    alu_out   = 16'h0000;
    alu_carry = 1'b0;
    s         = 17'h0;
    if (alu_opcode == `ALU_OP_SUB) begin
      alu_out   = (a - b) & m;
      alu_carry = (a < b);
    end else if (alu_opcode == `ALU_OP_ADD) begin
      s         = {1'b0, a} + {1'b0, b};
      alu_out   = s[15:0] & m;
      alu_carry = alu_select_word ? s[16] : s[8];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        err;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] all_outputs();
    return {6'b0, busy, done, divide_error, result_hi, result_lo, mul_overflow,
            alu_opcode, alu_source_1, alu_source_2, alu_select_word};
  endfunction

  // Monitor: compares on done and checks that results hold one cycle later.
  exp_t last;
  bit   hold_pending = 0;
  always @(negedge clock) begin
    if (hold_pending) begin
      hold_pending = 0;
      check({last.name, "_hold"}, {48'b0, done, result_hi, result_lo}, {48'b0, 1'b0, last.hi, last.lo});
    end
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        last = sb.pop_front();
        check({last.name, "_hi"},  {64'b0, result_hi}, {64'b0, last.hi});
        check({last.name, "_lo"},  {64'b0, result_lo}, {64'b0, last.lo});
        check({last.name, "_err"}, {79'b0, divide_error}, {79'b0, last.err});
        check({last.name, "_ovf"}, {79'b0, mul_overflow}, {79'b0, last.ovf});
        check({last.name, "_latency"}, 80'(cyc), 80'(last.done_cyc));
        check({last.name, "_alu_idle"}, {alu_opcode, alu_source_1, alu_source_2, alu_select_word}, 80'b0);
        $display("txn %s: hi=%04h lo=%04h err=%0b ovf=%0b at cycle %0d",
                 last.name, result_hi, result_lo, divide_error, mul_overflow, cyc);
        hold_pending = 1;
      end
    end
  end

  task automatic drive_start(input logic div, input logic word, input logic [15:0] hi,
                             input logic [15:0] lo, input logic [15:0] src);
    start = 1'b1; op_div = div; select_word = word;
    operand_hi = hi; operand_lo = lo; operand_src = src;
  endtask

  task automatic issue(input string name, input logic div, input logic word,
                       input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] src,
                       input logic [15:0] ehi, input logic [15:0] elo,
                       input logic eerr, input logic eovf, input int lat);
    exp_t e;
    @(negedge clock);
    drive_start(div, word, hi, lo, src);
    e.name = name; e.hi = ehi; e.lo = elo; e.err = eerr; e.ovf = eovf;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: got busy=%0b pending=%0d after 100 cycles, expected idle", busy, sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int c0;
    int k;
    reset = 1'b1; start = 1'b0; op_div = 1'b0; select_word = 1'b0;
    operand_hi = '0; operand_lo = '0; operand_src = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", all_outputs(), 80'b0);
    reset = 1'b0;

    //     name          div  word hi       lo       src      exp_hi   exp_lo  err  ovf lat
    issue("mul_b_ffxff", 0, 0, 16'h0000, 16'h00FF, 16'h00FF, 16'h00FE, 16'h0001, 0, 1, 9);  wait_idle();
    issue("mul_w_1234",  0, 1, 16'h0000, 16'h1234, 16'h0100, 16'h0012, 16'h3400, 0, 1, 17); wait_idle();
    issue("mul_w_3x5",   0, 1, 16'hFFFF, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 0, 0, 17); wait_idle();
    issue("mul_b_mask",  0, 0, 16'h0000, 16'hAB0F, 16'hCD10, 16'h0000, 16'h00F0, 0, 0, 9);  wait_idle();
    issue("div_w_10000", 1, 1, 16'h0001, 16'h0000, 16'h0003, 16'h0001, 16'h5555, 0, 0, 18); wait_idle();
    issue("div_b_100_7", 1, 0, 16'h0000, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 0, 0, 10); wait_idle();
    issue("div_b_zero",  1, 0, 16'h0000, 16'h0064, 16'h0000, 16'h0000, 16'h0000, 1, 0, 2);  wait_idle();
    issue("div_b_ovf",   1, 0, 16'h0002, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1, 0, 2);  wait_idle();
    issue("div_w_max",   1, 1, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 0, 0, 18); wait_idle();

    // start while busy and in the DONE cycle must both be ignored
    issue("mul_b_7x6", 0, 0, 16'h0000, 16'h0007, 16'h0006, 16'h0000, 16'h002A, 0, 0, 9);
    @(negedge clock);
    check("busy_mid_op", {79'b0, busy}, {79'b0, 1'b1});
    drive_start(1, 0, 16'h0000, 16'h0050, 16'h0000);
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
    end
    drive_start(1, 1, 16'h0000, 16'h0009, 16'h0003);
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clock);

    // reset during LOOP iteration 5 aborts with no done pulse
    @(negedge clock);
    drive_start(0, 0, 16'h0000, 16'h0055, 16'h0033);
    c0 = cyc;
    @(negedge clock);
    start = 1'b0;
    while (cyc < c0 + 6) @(negedge clock);
    check("loop_alu_add", {75'b0, alu_opcode}, {75'b0, `ALU_OP_ADD});
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_op", all_outputs(), 80'b0);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    check("after_abort", all_outputs(), 80'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
